dft_frame_sequencer: RTL and testbench



---
 rtl/dft_frame_sequencer_pkg.sv | 29 ++
 rtl/dft_frame_sequencer_twiddle_rom.sv | 32 +++
 rtl/dft_frame_sequencer.sv | 154 +++++++++++++++
 tb/tb_dft_frame_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_frame_sequencer_pkg.sv
// dft_pkg: shared state encoding, complex types and twiddle generation for dft_frame_sequencer
package dft_pkg;
    localparam int DFT_N     = 16;
    localparam int DFT_W     = 16;
    localparam int DFT_LOG2N = $clog2(DFT_N);
    localparam int DFT_ACC_W = 2*DFT_W + DFT_LOG2N + 1;
    localparam int TW_ONE    = 2**(DFT_W-2);

    typedef enum logic [1:0] {LOAD, MAC, OUT} state_t;

    typedef struct packed {
        logic signed [DFT_W-1:0] re;
        logic signed [DFT_W-1:0] im;
    } cplx_sample_t;

    typedef struct packed {
        logic signed [DFT_ACC_W-1:0] re;
        logic signed [DFT_ACC_W-1:0] im;
    } cplx_acc_t;

    // Q2.(w-2) twiddle for phase index m of n, rounded to nearest; sine selects -sin
    function automatic int tw_val(input int m, input int n, input int w, input bit sine);
        real a;
        real v;
        a = 2.0 * 3.14159265358979323846 * m / n;
        v = (sine ? -$sin(a) : $cos(a)) * (2.0 ** (w-2));
        return $rtoi($floor(v + 0.5));
    endfunction
endpackage

// File: rtl/dft_frame_sequencer_twiddle_rom.sv
// twiddle_rom: registered cos / -sin lookup in Q2.(W-2), contents built at elaboration
module twiddle_rom
    import dft_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 16
) (
    input  logic                    clk,
    input  logic [$clog2(N)-1:0]    i_addr,
    output logic signed [W-1:0]     o_cos,
    output logic signed [W-1:0]     o_nsin
);
    logic signed [W-1:0] w_cos_tab  [N];
    logic signed [W-1:0] w_nsin_tab [N];
    logic signed [W-1:0] r_cos;
    logic signed [W-1:0] r_nsin;

    for (genvar m = 0; m < N; m++) begin : g_tab
        localparam int C = tw_val(m, N, W, 1'b0);
        localparam int S = tw_val(m, N, W, 1'b1);
        assign w_cos_tab[m]  = W'(C);
        assign w_nsin_tab[m] = W'(S);
    end

    always_ff @(posedge clk) begin
        r_cos  <= w_cos_tab[i_addr];
        r_nsin <= w_nsin_tab[i_addr];
    end

    assign o_cos  = r_cos;
    assign o_nsin = r_nsin;
endmodule

// File: rtl/dft_frame_sequencer.sv
// dft_frame_sequencer: loads N complex samples, then streams X[0..N-1] from one complex MAC.
// Define DFT_INVERSE_EN to add the `inverse` input (positive-phase twiddles, no 1/N scaling).
module dft_frame_sequencer
    import dft_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 16,
    localparam int LOG2N = $clog2(N),
    localparam int ACC_W = 2*W + LOG2N + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef DFT_INVERSE_EN
    input  logic                    inverse,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W-1:0]     in_re,
    input  logic signed [W-1:0]     in_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_re,
    output logic signed [ACC_W-1:0] out_im,
    output logic [LOG2N-1:0]        out_idx,
    output logic                    busy
);
    state_t                 r_state;
    logic [LOG2N-1:0]       r_cnt;
    logic [LOG2N-1:0]       r_k;
    logic [LOG2N-1:0]       r_phase;
    logic [LOG2N:0]         r_j;
    logic signed [W-1:0]    r_buf_re [N];
    logic signed [W-1:0]    r_buf_im [N];
    logic signed [W-1:0]    r_xr;
    logic signed [W-1:0]    r_xi;
    logic signed [ACC_W-1:0] r_acc_re;
    logic signed [ACC_W-1:0] r_acc_im;
    logic signed [ACC_W-1:0] r_out_re;
    logic signed [ACC_W-1:0] r_out_im;
    logic                   r_out_valid;
`ifdef DFT_INVERSE_EN
    logic                   r_inv;
`endif
    logic signed [W-1:0]     w_cos;
    logic signed [W-1:0]     w_nsin;
    logic signed [ACC_W-1:0] w_c;
    logic signed [ACC_W-1:0] w_s;
    logic signed [ACC_W-1:0] w_xr;
    logic signed [ACC_W-1:0] w_xi;
    logic signed [ACC_W-1:0] w_sum_re;
    logic signed [ACC_W-1:0] w_sum_im;

    // Address is a running phase (phase += k), so no k*j multiplier is needed
    twiddle_rom #(.N(N), .W(W)) u_rom (
        .clk    (clk),
        .i_addr (r_phase),
        .o_cos  (w_cos),
        .o_nsin (w_nsin)
    );

    assign w_c  = ACC_W'(w_cos);
`ifdef DFT_INVERSE_EN
    assign w_s  = r_inv ? -ACC_W'(w_nsin) : ACC_W'(w_nsin);
`else
    assign w_s  = ACC_W'(w_nsin);
`endif
    assign w_xr = ACC_W'(r_xr);
    assign w_xi = ACC_W'(r_xi);
    assign w_sum_re = r_acc_re + w_c*w_xr - w_s*w_xi;
    assign w_sum_im = r_acc_im + w_c*w_xi + w_s*w_xr;

    always_ff @(posedge clk) begin
        if (r_state == LOAD && in_valid) begin
            r_buf_re[r_cnt] <= in_re;
            r_buf_im[r_cnt] <= in_im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOAD;
            r_cnt       <= '0;
            r_k         <= '0;
            r_j         <= '0;
            r_phase     <= '0;
            r_xr        <= '0;
            r_xi        <= '0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_valid <= 1'b0;
`ifdef DFT_INVERSE_EN
            r_inv       <= 1'b0;
`endif
        end else begin
            case (r_state)
                LOAD: if (in_valid) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LOG2N'(N-1)) begin
                        r_state  <= MAC;
                        r_k      <= '0;
                        r_j      <= '0;
                        r_phase  <= '0;
                        r_acc_re <= '0;
                        r_acc_im <= '0;
`ifdef DFT_INVERSE_EN
                        r_inv    <= inverse;
`endif
                    end
                end
                MAC: begin
                    r_j     <= r_j + 1'b1;
                    r_phase <= r_phase + r_k;
                    r_xr    <= r_buf_re[r_j[LOG2N-1:0]];
                    r_xi    <= r_buf_im[r_j[LOG2N-1:0]];
                    // ROM output lags the address by one cycle, so step j=0 only primes the pipe
                    if (r_j != '0) begin
                        r_acc_re <= w_sum_re;
                        r_acc_im <= w_sum_im;
                    end
                    if (r_j == (LOG2N+1)'(N)) begin
                        r_state     <= OUT;
                        r_out_re    <= w_sum_re;
                        r_out_im    <= w_sum_im;
                        r_out_valid <= 1'b1;
                    end
                end
                OUT: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_j         <= '0;
                    r_phase     <= '0;
                    r_acc_re    <= '0;
                    r_acc_im    <= '0;
                    if (r_k == LOG2N'(N-1)) begin
                        r_state <= LOAD;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= MAC;
                        r_k     <= r_k + 1'b1;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign in_ready  = (r_state == LOAD);
    assign busy      = (r_state != LOAD);
    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_idx   = r_k;
endmodule

// File: tb/tb_dft_frame_sequencer.sv
// tb_dft_frame_sequencer: directed frames (impulse, DC, tone, backpressure, mid-frame reset)
// with hand-computed expectations; DFT_INVERSE_EN adds an inverse-transform frame.
module tb_dft_frame_sequencer;
    localparam int N = 16;
    localparam int W = 16;
    localparam int LOG2N = 4;
    localparam int ACC_W = 37;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [W-1:0] in_re = '0;
    logic signed [W-1:0] in_im = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic signed [ACC_W-1:0] out_re;
    logic signed [ACC_W-1:0] out_im;
    logic [LOG2N-1:0] out_idx;
    logic busy;
`ifdef DFT_INVERSE_EN
    logic inverse = 1'b0;
`endif

    int n_assert = 0;
    int n_fail = 0;
    longint cyc = 0;
    int fr_re [N];
    int fr_im [N];

    dft_frame_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DFT_INVERSE_EN
        .inverse   (inverse),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input longint obs, input longint exp, input longint tol);
        n_assert++;
        assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    task automatic load_frame();
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_re = W'(fr_re[i]);
            in_im = W'(fr_im[i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for a bin, captures it, and consumes it if out_ready is high
    task automatic get_bin(output longint re, output longint im, output longint idx, output longint t);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        n_assert++;
        assert (out_valid === 1'b1) else begin
            n_fail++;
            $error("FAIL bin_timeout: out_valid %b expected 1", out_valid);
        end
        re = out_re;
        im = out_im;
        idx = out_idx;
        t = cyc;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

`ifdef DFT_INVERSE_EN
    function automatic longint rnd(input real v);
        return longint'($floor(v + 0.5));
    endfunction
`endif

    initial begin
        longint re, im, idx, t, t_prev;
        longint hold_re, hold_im;
        t_prev = 0;

        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Impulse (1000,0): every bin is 1000*16384, with junk offered on in_valid while busy
        for (int i = 0; i < N; i++) begin fr_re[i] = 0; fr_im[i] = 0; end
        fr_re[0] = 1000;
        load_frame();
        chk("imp_busy", busy, 1);
        chk("imp_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_re = 16'sd7777;
        in_im = -16'sd7777;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            get_bin(re, im, idx, t);
            chk("imp_re", re, 16384000);
            chk("imp_im", im, 0);
            chk("imp_idx", idx, k);
            if (k > 0) chk("imp_bin_period", t - t_prev, N + 2);
            t_prev = t;
            if (k < N - 1) chk("imp_in_ready_busy", in_ready, 0);
        end
        in_valid = 1'b0;
        chk("imp_done_in_ready", in_ready, 1);
        chk("imp_done_busy", busy, 0);
        chk("imp_done_out_valid", out_valid, 0);

        // DC 100 with 5 cycles of backpressure on bin 3
        for (int i = 0; i < N; i++) begin fr_re[i] = 100; fr_im[i] = 0; end
        load_frame();
        for (int k = 0; k < N; k++) begin
            if (k == 3) begin
                out_ready = 1'b0;
                get_bin(re, im, idx, t);
                hold_re = re;
                hold_im = im;
                repeat (5) begin
                    @(posedge clk); #1;
                    chk("bp_valid", out_valid, 1);
                    chk("bp_re", out_re, hold_re);
                    chk("bp_im", out_im, hold_im);
                    chk("bp_idx", out_idx, 3);
                    chk("bp_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
                @(posedge clk); #1;
                chk("bp_valid_drop", out_valid, 0);
            end else begin
                get_bin(re, im, idx, t);
            end
            chk("dc_idx", idx, k);
            if (k == 0) begin
                chk("dc_re0", re, 26214400);
                chk("dc_im0", im, 0);
            end else begin
                chk_near("dc_re", re, 0, 1600);
                chk_near("dc_im", im, 0, 1600);
            end
        end

        // Tone: x[j] = round(8192*cos(2*pi*2j/16))
        for (int i = 0; i < N; i++) begin
            case (i % 8)
                0: fr_re[i] = 8192;
                1: fr_re[i] = 5793;
                2: fr_re[i] = 0;
                3: fr_re[i] = -5793;
                4: fr_re[i] = -8192;
                5: fr_re[i] = -5793;
                6: fr_re[i] = 0;
                default: fr_re[i] = 5793;
            endcase
            fr_im[i] = 0;
        end
        load_frame();
        for (int k = 0; k < N; k++) begin
            get_bin(re, im, idx, t);
            chk("tone_idx", idx, k);
            if (k == 0) begin
                chk("tone_re0", re, 0);
                chk("tone_im0", im, 0);
            end
            if (k == 2 || k == 14) begin
                chk("tone_re_peak", re, 64'sd1073766152);
                chk("tone_im_peak", im, 0);
            end
        end

        // Reset during bin 7 accumulation, then a fresh impulse frame
        for (int i = 0; i < N; i++) begin fr_re[i] = 0; fr_im[i] = 0; end
        fr_re[0] = 1000;
        load_frame();
        for (int k = 0; k < 7; k++) begin
            get_bin(re, im, idx, t);
            chk("pre_rst_idx", idx, k);
        end
        repeat (6) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_re", out_re, 0);
        chk("mid_rst_out_im", out_im, 0);
        chk("mid_rst_out_idx", out_idx, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fr_re[0] = -500;
        fr_im[0] = 300;
        load_frame();
        for (int k = 0; k < N; k++) begin
            get_bin(re, im, idx, t);
            chk("post_rst_re", re, -8192000);
            chk("post_rst_im", im, 4915200);
            chk("post_rst_idx", idx, k);
        end

`ifdef DFT_INVERSE_EN
        // Inverse: X[1]=(16384,0) gives 16384*e^{+i*2*pi*k/16}
        for (int i = 0; i < N; i++) begin fr_re[i] = 0; fr_im[i] = 0; end
        fr_re[1] = 16384;
        inverse = 1'b1;
        load_frame();
        inverse = 1'b0;
        for (int k = 0; k < N; k++) begin
            get_bin(re, im, idx, t);
            chk("inv_idx", idx, k);
            chk_near("inv_re", re, 16384 * rnd(16384.0 * $cos(2.0 * 3.14159265358979 * k / N)), 16384);
            chk_near("inv_im", im, 16384 * rnd(16384.0 * $sin(2.0 * 3.14159265358979 * k / N)), 16384);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
